alu593_unit: RTL and testbench

- 8-bit-operand, 16-bit-result ALU with a start/done handshake. Driven by a bus-functional stimulus agent, checked by a scoreboard.
- Supports single-cycle logic/arithmetic ops, multi-cycle multiply, three special functions, and a one-entry store/load register. Reserved and no-op codes complete silently.

---
 rtl/alu593_unit.sv | 90 +++++++++
 tb/tb_alu593_unit.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/alu593_unit.sv
// alu593_unit: 8-bit operand ALU with start/done handshake, multi-cycle ops and a store register
module alu593_unit #(
  parameter int MUL_LAT  = 3,
  parameter int SPF1_LAT = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  A,
  input  logic [7:0]  B,
  input  logic [3:0]  op,
  input  logic        start,
  output logic        done,
  output logic [15:0] result
);
  typedef enum logic [1:0] {IDLE, BUSY, WAIT_LOW} state_t;
  state_t state_q, state_d;
  logic [7:0] a_q, a_d, b_q, b_d, cnt_q, cnt_d, lat;
  logic [3:0] op_q, op_d;
  logic done_q, done_d, exec;
  logic [15:0] res_q, res_d, store_q, store_d, calc;
  assign exec = op inside {[4'd1:4'd9]};
  assign lat = op == 4'd4 ? 8'(MUL_LAT - 1) : op == 4'd5 ? 8'(SPF1_LAT - 1) : 8'd0;
  assign done = done_q;
  assign result = res_q;
  // operation datapath on the latched operands
  always_comb begin
    case (op_q)
      4'd1:       calc = 16'(a_q) + 16'(b_q);
      4'd2:       calc = {8'h00, a_q & b_q};
      4'd3:       calc = {8'h00, a_q ^ b_q};
      4'd4:       calc = 16'(a_q) * 16'(b_q);
      4'd5:       calc = 16'(a_q) * 16'(a_q) + 16'(b_q);
      4'd6:       calc = 16'(a_q) - 16'(b_q);
      4'd7, 4'd9: calc = {a_q, b_q};
      4'd8:       calc = store_q;
      default:    calc = res_q;
    endcase
  end
  // handshake FSM: latch on start, count down, pulse done, wait for start to drop
  always_comb begin
    state_d = state_q;
    a_d = a_q;
    b_d = b_q;
    op_d = op_q;
    cnt_d = cnt_q;
    done_d = 1'b0;
    res_d = res_q;
    store_d = store_q;
    case (state_q)
      IDLE: if (start && exec) begin
        state_d = BUSY;
        a_d = A;
        b_d = B;
        op_d = op;
        cnt_d = lat;
      end
      BUSY: if (!start) state_d = IDLE;
      else if (cnt_q == 8'd0) begin
        state_d = WAIT_LOW;
        done_d = 1'b1;
        res_d = calc;
        store_d = op_q == 4'd9 ? {a_q, b_q} : store_q;
      end else cnt_d = cnt_q - 8'd1;
      WAIT_LOW: state_d = start ? WAIT_LOW : IDLE;
      default: state_d = IDLE;
    endcase
  end
  // state registers with synchronous reset (reset_n is active high)
  always_ff @(posedge clk) begin
    if (reset_n) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      op_q <= '0;
      cnt_q <= '0;
      done_q <= 1'b0;
      res_q <= '0;
      store_q <= '0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      op_q <= op_d;
      cnt_q <= cnt_d;
      done_q <= done_d;
      res_q <= res_d;
      store_q <= store_d;
    end
  end
endmodule

// File: tb/tb_alu593_unit.sv
// tb_alu593_unit: randomized and directed check of alu593_unit against a transaction-level model
module tb_alu593_unit;
  logic clk = 1'b0, reset_n = 1'b1, start = 1'b0;
  logic [7:0] A = '0, B = '0;
  logic [3:0] op = '0;
  logic done;
  logic [15:0] result;
  int total = 0, bad = 0;
  bit checking = 1'b0;
  logic exp_done = 1'b0;
  logic [15:0] exp_res = '0, st = '0;

  alu593_unit #(.MUL_LAT(3), .SPF1_LAT(4)) dut (
    .clk(clk), .reset_n(reset_n), .A(A), .B(B), .op(op),
    .start(start), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  function automatic int lat(input logic [3:0] o);
    return o == 4'd4 ? 3 : o == 4'd5 ? 4 : 1;
  endfunction

  function automatic bit is_exec(input logic [3:0] o);
    return o >= 4'd1 && o <= 4'd9;
  endfunction

  function automatic logic [15:0] model(input logic [3:0] o, input logic [7:0] a, input logic [7:0] b,
                                        input logic [15:0] s, input logic [15:0] cur);
    int x, y;
    x = a;
    y = b;
    case (o)
      4'd1: return 16'(x + y);
      4'd2: return 16'(x & y);
      4'd3: return 16'(x ^ y);
      4'd4: return 16'(x * y);
      4'd5: return 16'(x * x + y);
      4'd6: return 16'(x - y);
      4'd7, 4'd9: return 16'(x * 256 + y);
      4'd8: return s;
      default: return cur;
    endcase
  endfunction

  always @(negedge clk) if (checking) begin
    total++;
    if (done !== exp_done) begin
      bad++;
      $display("FAIL done act=%b exp=%b t=%0t", done, exp_done, $time);
    end
    total++;
    if (result !== exp_res) begin
      bad++;
      $display("FAIL result act=%h exp=%h t=%0t", result, exp_res, $time);
    end
  end

  task automatic check(input string n, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", n, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic run(input logic [3:0] o, input logic [7:0] a, input logic [7:0] b, input int extra);
    op = o;
    A = a;
    B = b;
    start = 1'b1;
    if (is_exec(o)) begin
      repeat (lat(o) + 1) tick;
      exp_done = 1'b1;
      exp_res = model(o, a, b, st, exp_res);
      if (o == 4'd9) st = {a, b};
      repeat (extra) begin
        tick;
        exp_done = 1'b0;
      end
      start = 1'b0;
      tick;
      exp_done = 1'b0;
    end else begin
      repeat (extra + 1) tick;
      start = 1'b0;
      tick;
    end
  endtask

  task automatic abort(input logic [3:0] o, input logic [7:0] a, input logic [7:0] b, input int k);
    op = o;
    A = a;
    B = b;
    start = 1'b1;
    repeat (k) tick;
    start = 1'b0;
    tick;
  endtask

  task automatic do_reset;
    reset_n = 1'b1;
    start = 1'b0;
    tick;
    exp_done = 1'b0;
    exp_res = '0;
    st = '0;
    reset_n = 1'b0;
  endtask

  initial begin
    tick;
    tick;
    checking = 1'b1;
    check("rst_result", result, 16'h0000);
    check("rst_done", 16'(done), 16'h0000);
    reset_n = 1'b0;
    tick;
    run(4'd1, 8'hFF, 8'hFF, 2);
    check("add_ff", result, 16'h01FE);
    check("add_ff_model", exp_res, 16'h01FE);
    run(4'd4, 8'hFF, 8'hFF, 0);
    check("mul_ff", result, 16'hFE01);
    check("mul_ff_model", exp_res, 16'hFE01);
    run(4'd2, 8'hF0, 8'h3C, 1);
    check("and", result, 16'h0030);
    run(4'd3, 8'hF0, 8'h3C, 0);
    check("xor", result, 16'h00CC);
    run(4'd5, 8'hFF, 8'hFF, 0);
    check("spf1", result, 16'hFF00);
    check("spf1_model", exp_res, 16'hFF00);
    run(4'd6, 8'h10, 8'h20, 0);
    check("spf2", result, 16'hFFF0);
    check("spf2_model", exp_res, 16'hFFF0);
    run(4'd7, 8'h12, 8'h34, 0);
    check("spf3", result, 16'h1234);
    run(4'd9, 8'hAB, 8'hCD, 0);
    check("store", result, 16'hABCD);
    run(4'd8, 8'h00, 8'h00, 0);
    check("load", result, 16'hABCD);
    check("load_model", exp_res, 16'hABCD);
    do_reset;
    run(4'd8, 8'h00, 8'h00, 0);
    check("load_after_rst", result, 16'h0000);
    run(4'd1, 8'h11, 8'h22, 0);
    run(4'd0, 8'h55, 8'h66, 5);
    run(4'd15, 8'h55, 8'h66, 5);
    run(4'd10, 8'h55, 8'h66, 5);
    check("noop_hold", result, 16'h0033);
    abort(4'd4, 8'h07, 8'h09, 1);
    check("abort_drop", result, 16'h0033);
    op = 4'd4;
    A = 8'h07;
    B = 8'h09;
    start = 1'b1;
    tick;
    do_reset;
    check("abort_rst", result, 16'h0000);
    run(4'd1, 8'h01, 8'h02, 0);
    check("add_1_2", result, 16'h0003);
    for (int i = 0; i < 400; i++) begin
      int r;
      logic [3:0] o;
      r = $urandom_range(0, 19);
      o = 4'($urandom_range(0, 15));
      if (r == 0) do_reset;
      else if (r < 4 && lat(o) > 1) abort(o, 8'($urandom), 8'($urandom), $urandom_range(1, lat(o) - 1));
      else run(o, 8'($urandom), 8'($urandom), $urandom_range(0, 2));
    end
    tick;
    checking = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
